// File: rtl/optimsoc_functions.sv
// rtl/optimsoc_functions.sv - shared constant helper functions
package optimsoc_functions;

   // Number of bits needed to encode values 0..value-1; clog2(1) is 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/noc_packet_buffer.sv
// rtl/noc_packet_buffer.sv - per-channel NoC flit FIFO with optional store-and-forward release
module noc_packet_buffer
   import optimsoc_functions::*;
#(
   parameter int FLIT_WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int FULLPACKET = 1,
   localparam int LEVEL_WIDTH = clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [FLIT_WIDTH-1:0]  in_flit,
   input  logic                   in_last,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [FLIT_WIDTH-1:0]  out_flit,
   output logic                   out_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LEVEL_WIDTH-1:0] level
);

   localparam int PTR_WIDTH = clog2(DEPTH);
   localparam logic [PTR_WIDTH-1:0] LAST_SLOT = PTR_WIDTH'(DEPTH - 1);
   localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(DEPTH);

   logic [FLIT_WIDTH:0]    mem [DEPTH];
   logic [FLIT_WIDTH:0]    head;
   logic [PTR_WIDTH-1:0]   wp;
   logic [PTR_WIDTH-1:0]   rp;
   logic [LEVEL_WIDTH-1:0] count;
   logic [LEVEL_WIDTH-1:0] pkt_count;
   logic                   ready_en;
   logic                   push;
   logic                   pop;
   logic                   head_last;

   assign head      = mem[rp];
   assign head_last = head[FLIT_WIDTH];

   // ready_en keeps in_ready low until the first edge after reset release
   assign in_ready = ready_en && (count != FULL_LEVEL);
   assign push     = in_valid && in_ready;
   assign pop      = out_valid && out_ready;

   // A full buffer releases even without a complete packet so oversize packets cannot deadlock
   always_comb begin
      out_valid = 1'b0;
      if (count != '0) begin
         if (FULLPACKET == 0) begin
            out_valid = 1'b1;
         end else begin
            out_valid = (pkt_count != '0) || (count == FULL_LEVEL);
         end
      end
   end

   assign out_flit = out_valid ? head[FLIT_WIDTH-1:0] : '0;
   assign out_last = out_valid && head_last;
   assign level    = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en  <= 1'b0;
         wp        <= '0;
         rp        <= '0;
         count     <= '0;
         pkt_count <= '0;
      end else begin
         ready_en <= 1'b1;
         if (push) begin
            wp <= (wp == LAST_SLOT) ? '0 : wp + 1'b1;
         end
         if (pop) begin
            rp <= (rp == LAST_SLOT) ? '0 : rp + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         case ({push && in_last, pop && head_last})
            2'b10:   pkt_count <= pkt_count + 1'b1;
            2'b01:   pkt_count <= pkt_count - 1'b1;
            default: pkt_count <= pkt_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp] <= {in_last, in_flit};
      end
   end

endmodule

// File: tb/tb_noc_packet_buffer.sv
// tb/tb_noc_packet_buffer.sv - directed self-checking bench for noc_packet_buffer
module tb_noc_packet_buffer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // u0: cut-through DEPTH=4; u1: store-and-forward DEPTH=16; u2: store-and-forward DEPTH=4
   logic [31:0] if0, if1, if2, of0, of1, of2;
   logic        il0, il1, il2, iv0, iv1, iv2, ir0, ir1, ir2;
   logic        ol0, ol1, ol2, ov0, ov1, ov2, or0, or1, or2;
   logic [2:0]  lvl0, lvl2;
   logic [4:0]  lvl1;

   int checks = 0;
   int errors = 0;

   noc_packet_buffer #(.FLIT_WIDTH(32), .DEPTH(4), .FULLPACKET(0)) u0 (
      .clk(clk), .rst_n(rst_n), .in_flit(if0), .in_last(il0), .in_valid(iv0), .in_ready(ir0),
      .out_flit(of0), .out_last(ol0), .out_valid(ov0), .out_ready(or0), .level(lvl0));
   noc_packet_buffer #(.FLIT_WIDTH(32), .DEPTH(16), .FULLPACKET(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_flit(if1), .in_last(il1), .in_valid(iv1), .in_ready(ir1),
      .out_flit(of1), .out_last(ol1), .out_valid(ov1), .out_ready(or1), .level(lvl1));
   noc_packet_buffer #(.FLIT_WIDTH(32), .DEPTH(4), .FULLPACKET(1)) u2 (
      .clk(clk), .rst_n(rst_n), .in_flit(if2), .in_last(il2), .in_valid(iv2), .in_ready(ir2),
      .out_flit(of2), .out_last(ol2), .out_valid(ov2), .out_ready(or2), .level(lvl2));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int idx_in;
      int got;
      bit seen_valid;
      bit saw_gap;

      rst_n = 1'b1;
      {if0, if1, if2} = '0;
      {il0, il1, il2, iv0, iv1, iv2, or0, or1, or2} = '0;

      // reset state
      #1 rst_n = 1'b0;
      #2;
      chk("rst_in_ready", {ir0, ir1, ir2}, 3'b000);
      chk("rst_out_valid", {ov0, ov1, ov2}, 3'b000);
      chk("rst_level", {lvl0, lvl1, lvl2}, 11'd0);
      tick();
      chk("rst_in_ready_edge", {ir0, ir1, ir2}, 3'b000);
      rst_n = 1'b1;
      chk("release_before_edge", ir0, 1'b0);
      tick();
      chk("release_in_ready", {ir0, ir1, ir2}, 3'b111);

      // cut-through 3-flit packet
      or0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         iv0 = 1'b1;
         if0 = 32'hA000_0001 + i;
         il0 = (i == 2);
         tick();
         chk("ct_valid", ov0, 1'b1);
         chk("ct_flit", of0, 32'hA000_0001 + i);
         chk("ct_last", ol0, (i == 2));
      end
      iv0 = 1'b0;
      il0 = 1'b0;
      tick();
      chk("ct_drain_valid", ov0, 1'b0);
      chk("ct_drain_level", lvl0, 3'd0);
      chk("ct_drain_flit", of0, 32'h0);

      // store-and-forward, 5 flits with gaps
      or1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         iv1 = 1'b1;
         if1 = 32'hB000_0000 + i;
         il1 = (i == 4);
         tick();
         iv1 = 1'b0;
         il1 = 1'b0;
         if (i < 4) begin
            chk("sf_hold_push", ov1, 1'b0);
            tick();
            chk("sf_hold_gap", ov1, 1'b0);
         end
      end
      for (int j = 0; j < 5; j++) begin
         chk("sf_stream_valid", ov1, 1'b1);
         chk("sf_stream_flit", of1, 32'hB000_0000 + j);
         chk("sf_stream_last", ol1, (j == 4));
         tick();
      end
      chk("sf_done_valid", ov1, 1'b0);
      chk("sf_done_level", lvl1, 5'd0);

      // full and wrap-around
      or2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         iv2 = 1'b1;
         if2 = 32'hC000_0000 + i;
         il2 = 1'b1;
         tick();
      end
      if2 = 32'hC000_0004;
      chk("full_level", lvl2, 3'd4);
      chk("full_in_ready", ir2, 1'b0);
      tick();
      chk("full_drop_level", lvl2, 3'd4);
      chk("full_head", of2, 32'hC000_0000);
      or2 = 1'b1;
      tick();
      chk("wrap_pop1_head", of2, 32'hC000_0001);
      chk("wrap_pop1_level", lvl2, 3'd3);
      chk("wrap_pop1_ready", ir2, 1'b1);
      tick();
      chk("wrap_pop2_head", of2, 32'hC000_0002);
      chk("wrap_pop2_level", lvl2, 3'd3);
      if2 = 32'hC000_0005;
      or2 = 1'b0;
      tick();
      chk("wrap_refill_level", lvl2, 3'd4);
      iv2 = 1'b0;
      or2 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("wrap_order_valid", ov2, 1'b1);
         chk("wrap_order_flit", of2, 32'hC000_0002 + i);
         tick();
      end
      chk("wrap_empty_level", lvl2, 3'd0);
      chk("wrap_empty_valid", ov2, 1'b0);

      // deadlock fallback: 6-flit packet into 4 slots
      idx_in = 0;
      got = 0;
      seen_valid = 1'b0;
      saw_gap = 1'b0;
      or2 = 1'b1;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         iv2 = (idx_in < 6);
         if2 = 32'hD000_0000 + idx_in;
         il2 = (idx_in == 5);
         if (ov2 && !seen_valid) begin
            seen_valid = 1'b1;
            chk("fb_rise_level", lvl2, 3'd4);
         end
         if (!ov2 && got > 0) saw_gap = 1'b1;
         if (ov2) begin
            chk("fb_flit", of2, 32'hD000_0000 + got);
            chk("fb_last", ol2, (got == 5));
            got++;
         end
         if (iv2 && ir2) idx_in++;
         tick();
      end
      iv2 = 1'b0;
      il2 = 1'b0;
      chk("fb_delivered", got, 6);
      chk("fb_mid_gap", saw_gap, 1'b1);
      chk("fb_end_level", lvl2, 3'd0);

      // simultaneous last push and last pop
      or2 = 1'b0;
      iv2 = 1'b1;
      il2 = 1'b1;
      if2 = 32'hE000_0000;
      tick();
      if2 = 32'hE000_0001;
      tick();
      iv2 = 1'b0;
      chk("sim_pre_level", lvl2, 3'd2);
      chk("sim_pre_pkt", u2.pkt_count, 3'd2);
      chk("sim_pre_head", of2, 32'hE000_0000);
      iv2 = 1'b1;
      if2 = 32'hE000_0002;
      or2 = 1'b1;
      tick();
      iv2 = 1'b0;
      chk("sim_level", lvl2, 3'd2);
      chk("sim_pkt", u2.pkt_count, 3'd2);
      chk("sim_valid", ov2, 1'b1);
      chk("sim_head", of2, 32'hE000_0001);
      tick();
      tick();
      chk("sim_drain_level", lvl2, 3'd0);
      chk("sim_drain_pkt", u2.pkt_count, 3'd0);

      // reset mid-packet on cut-through instance
      or0 = 1'b0;
      iv0 = 1'b1;
      il0 = 1'b0;
      if0 = 32'h6000_0000;
      tick();
      if0 = 32'h6000_0001;
      tick();
      iv0 = 1'b0;
      chk("mid_level", lvl0, 3'd2);
      chk("mid_valid", ov0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", ov0, 1'b0);
      chk("async_level", lvl0, 3'd0);
      chk("async_flit", of0, 32'h0);
      chk("async_in_ready", ir0, 1'b0);
      #1 rst_n = 1'b1;
      tick();
      chk("rerun_ready", ir0, 1'b1);
      chk("rerun_valid", ov0, 1'b0);
      or0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         iv0 = 1'b1;
         if0 = 32'h7000_0000 + i;
         il0 = (i == 2);
         tick();
         chk("rerun_flit", of0, 32'h7000_0000 + i);
         chk("rerun_last", ol0, (i == 2));
      end
      iv0 = 1'b0;
      tick();
      chk("rerun_level", lvl0, 3'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/noc_packet_buffer.md
# noc_packet_buffer

Single-channel NoC flit FIFO placed directly downstream of a compute tile's `noc_out_*` port (one instance per channel) before the router input. It decouples tile and router timing and, in store-and-forward mode, releases a packet to the router only once its last flit is stored. This keeps a stalled tile from holding a router link mid-packet.

## Interface
Parameters:
- `FLIT_WIDTH`, default 32: flit payload width in bits.
- `DEPTH`, default 16: number of flit slots. Must be at least 2; need not be a power of two.
- `FULLPACKET`, default 1:
  - 1 = store-and-forward.
  - 0 = cut-through.
- `LEVEL_WIDTH` (localparam) = `clog2(DEPTH+1)`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  block clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_flit`  in  FLIT_WIDTH  flit from the tile.
- `in_last`  in  1  marks the final flit of a packet.
- `in_valid`  in  1  input flit is valid.
- `in_ready`  out  1  buffer accepts the flit this cycle.
- `out_flit`  out  FLIT_WIDTH  head flit toward the router.
- `out_last`  out  1  head flit is the last of its packet.
- `out_valid`  out  1  head flit is presentable.
- `out_ready`  in  1  router accepts the head flit.
- `level`  out  LEVEL_WIDTH  number of flits stored.

## Operation
- Storage is a circular register array of `{last, flit}` entries.
  - Write pointer `wp` and read pointer `rp` each wrap from DEPTH-1 to 0.
  - `count` tracks occupancy (0..DEPTH).
- Push condition: `in_valid && in_ready`. Writes `{in_last, in_flit}` at `wp`; `wp` advances.
- Pop condition: `out_valid && out_ready`. `rp` advances.
- `in_ready = (count < DEPTH)`. A full buffer never accepts a push, even when a pop occurs in the same cycle (no full-bypass).
- `count` update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- `pkt_count` (0..DEPTH) holds the number of stored `last` flits.
  - Increments on push with `in_last`.
  - Decrements on pop of a `last` entry.
  - Unchanged when both happen in the same cycle.
- `out_valid`:
  - FULLPACKET=0: `count > 0`.
  - FULLPACKET=1: `count > 0 && (pkt_count > 0 || count == DEPTH)`. The `count == DEPTH` term is the deadlock fallback: a packet longer than DEPTH drains in cut-through fashion.
- `out_flit` and `out_last` present the entry at `rp` (first-word fall-through). Both are forced to 0 whenever `out_valid` = 0.
- `out_valid` may drop between flits of one packet (fallback drain, or cut-through underrun). The router tolerates this.
- `level = count`.
- Handshake rules:
  - Upstream: `in_flit`/`in_last` must stay stable while `in_valid && !in_ready`.
  - Downstream: once `out_valid` rises, the block holds the same head until it is popped. The only exception is reset.
- Reset (`rst_n` low, asynchronous): `wp`, `rp`, `count`, `pkt_count` = 0. Storage is not reset.
- Reset during a packet discards all stored flits, including partial packets. No recovery framing is attempted.

## Timing
- Output values while `rst_n` is low:
  - `in_ready` = 0 (gated by reset).
  - `out_valid`, `out_flit`, `out_last`, `level` = 0.
- `in_ready` = 1 from the first clock edge after `rst_n` deasserts.
- Cut-through latency: a flit pushed at edge N appears on `out_*` after edge N (one cycle).
- Store-and-forward latency: `out_valid` rises one cycle after the edge that pushes the `last` flit. The first flit of that packet is then presented.
- Throughput: one push and one pop per cycle, sustained.
- `level` reflects the count registered at the previous edge.
- No combinational path from `in_*` to `out_*`, or from `out_ready` to `in_ready`.

## Structure
- Use `clog2` from `optimsoc_functions`. No new package typedefs are needed; the entry is a local packed `{last, flit}`.
- No sub-module: storage and pointers are inline, keeping RTL around 150 lines.
- The tile-level wrapper instantiates one instance per channel via generate.

## Test plan
- Cut-through, DEPTH=4, FULLPACKET=0. Push 3-flit packet A1,A2,A3 with `out_ready`=1. Require:
  - each flit appears one cycle after its push;
  - `out_last` only on A3;
  - `level` returns to 0.
- Store-and-forward, DEPTH=16. Push 5 flits with 1-cycle gaps. Require:
  - `out_valid` stays 0 until the cycle after the `last` push;
  - all 5 flits then stream back-to-back.
- Full and wrap-around. Fill DEPTH=4 with `out_ready`=0. Require:
  - `in_ready` = 0 at `level` = 4;
  - a push attempt while full is dropped and `in_flit` is held.

  Then pop 2 and push 2 (pointers wrap). Require output order to be preserved.
- Deadlock fallback, DEPTH=4, FULLPACKET=1. Send a 6-flit packet. Require:
  - `out_valid` rises when `level` hits 4;
  - all 6 flits are delivered in order;
  - `out_valid` stays low in at least one cycle mid-packet.
- Simultaneous events. With 2 complete 1-flit packets stored, push a `last` flit while popping a `last` flit in the same cycle. Require `pkt_count` and `level` unchanged and `out_valid` staying 1.
- Reset mid-packet. Assert `rst_n` low after 2 of 3 flits are pushed. Require:
  - `out_valid` and `level` drop to 0 immediately (asynchronous);
  - after release, a fresh packet passes cleanly.
